// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state type and default constants for clk12_monitor.
// Defaults describe a 50 MHz reference qualifying a 12 MHz PLL clock.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_QUAL    = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_GATE_CYCLES  = 50000;
  localparam int unsigned DEF_EXP_COUNT    = 12000;
  localparam int unsigned DEF_TOL          = 12;
  localparam int unsigned DEF_LOCK_WINDOWS = 4;
  localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/sync2.sv
// sync2: generic two-flop synchronizer for a single asynchronous bit.
// Ports: i_clk, i_rst_n (async low), i_d (async in), o_q (synced out).
module sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/clk12_monitor.sv
// clk12_monitor: counts PLL clock edges per gate window in the refclk
// domain and qualifies the clock after LOCK_WINDOWS good windows.
// Ports: refclk, rst_n (async low), mon_clk, pll_locked, fault_clr in;
// clk_ok, meas_valid, meas_count, fault out.
// CLK12_MON_STATS_EN adds meas_min / meas_max running statistics.
module clk12_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int unsigned EXP_COUNT    = DEF_EXP_COUNT,
  parameter int unsigned TOL          = DEF_TOL,
  parameter int unsigned LOCK_WINDOWS = DEF_LOCK_WINDOWS,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             pll_locked,
  input  logic             fault_clr,
  output logic             clk_ok,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             fault
`ifdef CLK12_MON_STATS_EN
  ,
  output logic [CNT_W-1:0] meas_min,
  output logic [CNT_W-1:0] meas_max
`endif
);

  localparam int unsigned GATE_W =
    (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [GATE_W-1:0] GATE_LAST =
    GATE_W'(GATE_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST =
    GOOD_W'(LOCK_WINDOWS - 1);

  // Bounds are one bit wider than the counter so that
  // EXP_COUNT + TOL never wraps; the low bound clamps at 0.
  localparam logic [CNT_W:0] LO_BOUND = (CNT_W+1)'(
    (EXP_COUNT > TOL) ? (EXP_COUNT - TOL) : 0);
  localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(
    EXP_COUNT + TOL);

  logic              w_mon_s2;
  logic              w_lock_s;
  logic              r_mon_s3;
  logic              w_edge;

  mon_state_e        r_state;
  mon_state_e        w_state_nxt;

  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [GOOD_W-1:0] w_good_nxt;

  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_result;
  logic              w_term;
  logic              w_good;
  logic              w_run;
  logic              w_fire;
  logic              w_fault_set;

  logic              r_meas_valid;
  logic [CNT_W-1:0]  r_meas_count;
  logic              r_fault;

  sync2 u_sync_mon (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (mon_clk),
    .o_q     (w_mon_s2)
  );

  sync2 u_sync_lock (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_mon_s3 <= 1'b0;
    end else begin
      r_mon_s3 <= w_mon_s2;
    end
  end

  assign w_edge = w_mon_s2 & ~r_mon_s3;
  assign w_term = (r_gate_cnt == GATE_LAST);

  // An edge landing in the terminal cycle still belongs to
  // the closing window; saturate like the counter itself.
  assign w_sum = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_edge};
  assign w_result = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  assign w_good = ({1'b0, w_result} >= LO_BOUND) &&
                  ({1'b0, w_result} <= HI_BOUND);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_run       = 1'b0;
    w_fire      = 1'b0;
    w_fault_set = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_good_nxt = '0;
        if (w_lock_s) begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE, ST_QUAL: begin
        if (!w_lock_s) begin
          // Abort the window; only a qualified clock faults.
          w_state_nxt = ST_IDLE;
          w_good_nxt  = '0;
          w_fault_set = (r_state == ST_QUAL);
        end else begin
          w_run = 1'b1;
          if (w_term) begin
            w_fire = 1'b1;
            if (w_good) begin
              if (r_state == ST_MEASURE) begin
                w_good_nxt = r_good_cnt + 1'b1;
                if (r_good_cnt == GOOD_LAST) begin
                  w_state_nxt = ST_QUAL;
                end
              end
            end else begin
              w_good_nxt = '0;
              if (r_state == ST_QUAL) begin
                w_state_nxt = ST_MEASURE;
                w_fault_set = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
    end else if (!w_run || w_term) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
      if (w_edge && !(&r_edge_cnt)) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_valid <= 1'b0;
      r_meas_count <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_meas_valid <= w_fire;
      if (w_fire) begin
        r_meas_count <= w_result;
      end
      // A set in the same cycle as a clear must win.
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (fault_clr) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign clk_ok     = (r_state == ST_QUAL);
  assign meas_valid = r_meas_valid;
  assign meas_count = r_meas_count;
  assign fault      = r_fault;

`ifdef CLK12_MON_STATS_EN
  logic [CNT_W-1:0] r_meas_min;
  logic [CNT_W-1:0] r_meas_max;

  // Statistics restart whenever the block leaves IDLE.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_min <= '1;
      r_meas_max <= '0;
    end else if (r_state == ST_IDLE && w_lock_s) begin
      r_meas_min <= '1;
      r_meas_max <= '0;
    end else if (w_fire) begin
      if (w_result < r_meas_min) begin
        r_meas_min <= w_result;
      end
      if (w_result > r_meas_max) begin
        r_meas_max <= w_result;
      end
    end
  end

  assign meas_min = r_meas_min;
  assign meas_max = r_meas_max;
`endif

endmodule

// File: tb/tb_clk12_monitor.sv
// tb_clk12_monitor: scoreboard bench for clk12_monitor with short
// sim windows (500 ref cycles, 120 expected edges, TOL 2).
`timescale 1ns/1ps
module tb_clk12_monitor;

  localparam int unsigned GC = 500;
  localparam int unsigned EC = 120;
  localparam int unsigned TL = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned CW = 16;

  logic          refclk     = 1'b0;
  logic          rst_n      = 1'b0;
  logic          mon_clk    = 1'b0;
  logic          pll_locked = 1'b0;
  logic          fault_clr  = 1'b0;
  logic          clk_ok;
  logic          meas_valid;
  logic [CW-1:0] meas_count;
  logic          fault;
`ifdef CLK12_MON_STATS_EN
  logic [CW-1:0] meas_min;
  logic [CW-1:0] meas_max;
`endif

  clk12_monitor #(
    .GATE_CYCLES  (GC),
    .EXP_COUNT    (EC),
    .TOL          (TL),
    .LOCK_WINDOWS (LW),
    .CNT_W        (CW)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .mon_clk    (mon_clk),
    .pll_locked (pll_locked),
    .fault_clr  (fault_clr),
    .clk_ok     (clk_ok),
    .meas_valid (meas_valid),
    .meas_count (meas_count),
    .fault      (fault)
`ifdef CLK12_MON_STATS_EN
    ,
    .meas_min   (meas_min),
    .meas_max   (meas_max)
`endif
  );

  always #10 refclk = ~refclk;

  realtime mon_half = 41.667;
  bit      mon_en   = 1'b1;

  always begin
    #(mon_half);
    if (mon_en) mon_clk = ~mon_clk;
  end

  typedef struct {
    int lo;
    int hi;
    bit ok;
    bit flt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   win_n    = 0;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic push(input int lo, input int hi,
                      input bit ok, input bit flt);
    exp_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.ok  = ok;
    e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge refclk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_ok"}, clk_ok, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_meas_count"}, meas_count, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  always @(negedge refclk) begin
    exp_t e;
    if (rst_n && meas_valid) begin
      win_n++;
      if (sb.size() == 0) begin
        chk($sformatf("unexpected_meas_valid_w%0d", win_n),
            1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("w%0d_count_in_%0d_%0d(cnt=%0d)",
                      win_n, e.lo, e.hi, meas_count),
            (meas_count >= CW'(e.lo)) &&
            (meas_count <= CW'(e.hi)), 1);
        chk($sformatf("w%0d_clk_ok", win_n), clk_ok, e.ok);
        chk($sformatf("w%0d_fault", win_n), fault, e.flt);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cycles(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Nominal 12 MHz: qualify on the 4th window.
    cycles(7);
    for (int i = 0; i < 3; i++) push(EC-1, EC+1, 0, 0);
    push(EC-1, EC+1, 1, 0);
    push(EC-1, EC+1, 1, 0);
    pll_locked = 1'b1;
    drain(5*GC + 100);

    // One dead window while qualified.
    mon_en = 1'b0;
    push(0, EC-3, 0, 1);
    drain(GC + 50);
    pll_locked = 1'b0;
    mon_en = 1'b1;
    cycles(20);
    chk("glitch_clk_ok", clk_ok, 0);
    chk("glitch_fault", fault, 1);
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    chk("clr_after_glitch", fault, 0);

    // Relock needs four fresh good windows.
    for (int i = 0; i < 3; i++) push(EC-1, EC+1, 0, 0);
    push(EC-1, EC+1, 1, 0);
    pll_locked = 1'b1;
    drain(4*GC + 100);
    chk("relock_clk_ok", clk_ok, 1);

    // Lock drop mid-window, fault_clr in the set cycle.
    cycles(200);
    pll_locked = 1'b0;
    cycles(1);
    chk("drop_clk_ok_c1", clk_ok, 1);
    cycles(1);
    chk("drop_clk_ok_c2", clk_ok, 1);
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    chk("drop_clk_ok_c3", clk_ok, 0);
    chk("collision_fault", fault, 1);
    cycles(GC + 50);
    chk("drop_fault_held", fault, 1);
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    chk("clr_isolated", fault, 0);

    // 10 MHz never qualifies and never faults.
    mon_half = 50.0;
    cycles(10);
    for (int i = 0; i < 3; i++) push(99, 101, 0, 0);
    pll_locked = 1'b1;
    drain(3*GC + 100);
    chk("wrongf_clk_ok", clk_ok, 0);
    chk("wrongf_fault", fault, 0);

    // Reset mid-window discards the partial count.
    cycles(200);
    rst_n = 1'b0;
    cycles(1);
    chk_reset_vals("midrst");
    cycles(2);
    push(99, 101, 0, 0);
    rst_n = 1'b1;
    n = 0;
    while (!meas_valid && n < GC + 200) begin
      @(negedge refclk);
      n++;
    end
    chk("midrst_valid_latency", n, GC + 3);
    cycles(2);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
